// File: rtl/proc_instr_feeder_if.sv
// rtl/proc_instr_feeder_if.sv - instruction memory read bus plus processor DIN/Run/Done handshake
interface proc_instr_feeder_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] DIN;
  logic          Run;
  logic          Done;

  // master is the feeder; slave is the memory/processor side
  modport master (
    output mem_addr,
    output DIN,
    output Run,
    input  mem_data,
    input  Done
  );

  modport slave (
    input  mem_addr,
    input  DIN,
    input  Run,
    output mem_data,
    output Done
  );
endinterface

// File: rtl/proc_instr_feeder.sv
// rtl/proc_instr_feeder.sv - fetches instructions (and mvi immediates) and steps the processor via Run/Done
// Optional hang watchdog enabled by defining WATCHDOG_EN.
module proc_instr_feeder #(
  parameter int            AW        = 5,
  parameter int            DW        = 16,
  parameter logic [DW-1:0] HALT_WORD = 16'hFFFF,
  parameter int            MAX_STEPS = 8
) (
  input  logic                clock,
  input  logic                Resetn,
  input  logic                start,
  proc_instr_feeder_if.master bus,
  output logic [AW-1:0]       pc,
  output logic [15:0]         instr_count,
  output logic                halted,
  output logic                timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_I,
    S_LOAD_I,
    S_REQ_IMM,
    S_LOAD_IMM,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_MVI = 3'b001;

  state_t        state;
  state_t        state_nx;
  logic [DW-1:0] ir_reg;
  logic [DW-1:0] imm_reg;
  logic [3:0]    exec_cnt;
  logic          is_mvi;
  logic          retire;
  logic          wd_fire;

  assign is_mvi = (ir_reg[8:6] == OP_MVI);

  // A Done seen in the first EXEC cycle is the previous instruction's strobe still high.
  assign retire = (state == S_EXEC) && bus.Done && (exec_cnt != 4'd0);

`ifdef WATCHDOG_EN
  localparam logic [3:0] WD_LAST = 4'(MAX_STEPS - 1);
  assign wd_fire = (state == S_EXEC) && !retire && (exec_cnt == WD_LAST);
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    bus.Run      = 1'b0;
    bus.DIN      = '0;
    bus.mem_addr = pc;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_REQ_I;
      end
      S_REQ_I: begin
        state_nx = S_LOAD_I;
      end
      S_LOAD_I: begin
        if (bus.mem_data == HALT_WORD)        state_nx = S_HALT;
        else if (bus.mem_data[8:6] == OP_MVI) state_nx = S_REQ_IMM;
        else                                  state_nx = S_EXEC;
      end
      S_REQ_IMM: begin
        bus.mem_addr = pc + AW'(1);
        state_nx     = S_LOAD_IMM;
      end
      S_LOAD_IMM: begin
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        bus.Run = 1'b1;
        bus.DIN = (is_mvi && (exec_cnt != 4'd0)) ? imm_reg : ir_reg;
        if (retire)       state_nx = S_REQ_I;
        else if (wd_fire) state_nx = S_HALT;
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!Resetn) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr_count <= 16'd0;
      ir_reg      <= '0;
      imm_reg     <= '0;
      exec_cnt    <= 4'd0;
      halted      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_LOAD_I) begin
        ir_reg   <= bus.mem_data;
        exec_cnt <= 4'd0;
      end
      if (state == S_LOAD_IMM) begin
        imm_reg  <= bus.mem_data;
        exec_cnt <= 4'd0;
      end
      if ((state == S_EXEC) && (exec_cnt != 4'hF)) begin
        exec_cnt <= exec_cnt + 4'd1;
      end
      if (retire) begin
        pc          <= pc + (is_mvi ? AW'(2) : AW'(1));
        instr_count <= instr_count + 16'd1;
      end
      if ((state_nx == S_HALT) && (state != S_HALT)) begin
        halted <= 1'b1;
      end
    end
  end

`ifdef WATCHDOG_EN
  always_ff @(posedge clock) begin
    if (!Resetn)      timeout <= 1'b0;
    else if (wd_fire) timeout <= 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_proc_instr_feeder.sv
// tb/tb_proc_instr_feeder.sv - scoreboard bench: memory and processor models, DIN stream checked per Run cycle
module tb_proc_instr_feeder;
  localparam int          AW   = 5;
  localparam int          DW   = 16;
  localparam logic [15:0] HALT = 16'hFFFF;

  logic          clock  = 1'b0;
  logic          Resetn = 1'b0;
  logic          start  = 1'b0;
  logic [AW-1:0] pc;
  logic [15:0]   instr_count;
  logic          halted;
  logic          timeout;

  proc_instr_feeder_if #(.AW(AW), .DW(DW)) bus ();

  proc_instr_feeder #(
    .AW(AW), .DW(DW), .HALT_WORD(HALT), .MAX_STEPS(8)
  ) dut (
    .clock(clock),
    .Resetn(Resetn),
    .start(start),
    .bus(bus.master),
    .pc(pc),
    .instr_count(instr_count),
    .halted(halted),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] mem [32];
  logic [15:0] exp_q [$];
  int          done_at_q [$];
  bit          sticky_q [$];
  bit          sb_en    = 1'b1;
  int          run_seen = 0;
  int          run_cnt  = 0;
  bit          hold     = 1'b0;
  logic [15:0] exp_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // synchronous-read instruction memory
  always @(posedge clock) bus.mem_data <= mem[bus.mem_addr];

  // processor model: Done after done_at_q[0] Run cycles; sticky holds Done into the next instruction
  initial bus.Done = 1'b0;
  always @(posedge clock) begin
    if (!Resetn) begin
      run_cnt = 0;
      hold    = 1'b0;
    end else if (bus.Run) begin
      if (bus.Done && run_cnt >= 1) begin
        hold = (sticky_q.size() != 0) ? sticky_q[0] : 1'b0;
        if (done_at_q.size() != 0) void'(done_at_q.pop_front());
        if (sticky_q.size() != 0) void'(sticky_q.pop_front());
        run_cnt = 0;
      end else begin
        if (run_cnt == 0) hold = 1'b0;
        run_cnt++;
      end
    end
    #2;
    bus.Done = (bus.Run && (run_cnt == ((done_at_q.size() != 0) ? done_at_q[0] : 1000))) || hold;
  end

  // monitor: every Run cycle consumes one expected DIN word
  always @(negedge clock) begin
    if (Resetn) begin
      if (bus.Run) begin
        run_seen++;
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL din_extra actual=%h required=none", bus.DIN);
          end else begin
            exp_w = exp_q.pop_front();
            check("din", {16'd0, bus.DIN}, {16'd0, exp_w});
          end
        end
      end else if (halted) begin
        check("din_halt", {16'd0, bus.DIN}, 32'd0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    start  = 1'b0;
    tick(2);
    Resetn = 1'b1;
    sb_en  = 1'b1;
    exp_q.delete();
    done_at_q.delete();
    sticky_q.delete();
    for (int i = 0; i < 32; i++) mem[i] = HALT;
  endtask

  task automatic wait_halt(input int max, input string name);
    int n;
    n = 0;
    while (!halted && n < max) begin
      tick();
      n++;
    end
    check(name, {31'd0, halted}, 32'd1);
  endtask

  task automatic finish_test(input string name, input logic [AW-1:0] epc, input logic [15:0] ecnt,
                             input logic eto);
    check({name, "_queue_left"}, exp_q.size(), 32'd0);
    check({name, "_pc"}, {27'd0, pc}, {27'd0, epc});
    check({name, "_instr_count"}, {16'd0, instr_count}, {16'd0, ecnt});
    check({name, "_timeout"}, {31'd0, timeout}, {31'd0, eto});
    check({name, "_run_low"}, {31'd0, bus.Run}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) mem[i] = HALT;
    do_reset();
    check("rst_run", {31'd0, bus.Run}, 32'd0);
    check("rst_din", {16'd0, bus.DIN}, 32'd0);
    check("rst_pc", {27'd0, pc}, 32'd0);
    check("rst_mem_addr", {27'd0, bus.mem_addr}, 32'd0);
    check("rst_instr_count", {16'd0, instr_count}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);

    // 1: reset while Run is high
    mem[0] = 16'h000A;
    exp_q.push_back(16'h000A);
    exp_q.push_back(16'h000A);
    run_seen = 0;
    start = 1'b1;
    n = 0;
    while (run_seen < 2 && n < 20) begin
      tick();
      n++;
    end
    check("t1_run_reached", run_seen, 32'd2);
    Resetn = 1'b0;
    start  = 1'b0;
    tick();
    check("t1_run_after_rst", {31'd0, bus.Run}, 32'd0);
    check("t1_pc_after_rst", {27'd0, pc}, 32'd0);
    check("t1_cnt_after_rst", {16'd0, instr_count}, 32'd0);
    Resetn = 1'b1;
    tick(2);
    check("t1_idle_hold_run", {31'd0, bus.Run}, 32'd0);
    check("t1_idle_mem_addr", {27'd0, bus.mem_addr}, 32'd0);
    check("t1_queue_left", exp_q.size(), 32'd0);

    // 2: mv then HALT, refetching address 0
    mem[1] = HALT;
    done_at_q.push_back(1);
    exp_q.push_back(16'h000A);
    exp_q.push_back(16'h000A);
    start = 1'b1;
    wait_halt(40, "t2_halt_reached");
    finish_test("t2", 5'd1, 16'd1, 1'b0);
    tick(3);
    check("t2_halt_sticks", {31'd0, halted}, 32'd1);
    check("t2_halt_run", {31'd0, bus.Run}, 32'd0);

    // 3: mvi immediate on second Run cycle
    do_reset();
    mem[0] = 16'h0048;
    mem[1] = 16'h1234;
    done_at_q.push_back(1);
    exp_q.push_back(16'h0048);
    exp_q.push_back(16'h1234);
    start = 1'b1;
    wait_halt(40, "t3_halt_reached");
    finish_test("t3", 5'd2, 16'd1, 1'b0);

    // 4: mvi at pc=31 fetches immediate from address 0, pc wraps to 1
    do_reset();
    mem[0] = 16'h0003;
    for (int i = 1; i < 31; i++) mem[i] = 16'h000A;
    mem[31] = 16'h0048;
    for (int i = 0; i < 32; i++) done_at_q.push_back(1);
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0003);
    for (int i = 1; i < 31; i++) begin
      exp_q.push_back(16'h000A);
      exp_q.push_back(16'h000A);
    end
    exp_q.push_back(16'h0048);
    exp_q.push_back(16'h0003);
    start = 1'b1;
    n = 0;
    while (pc != 5'd31 && n < 400) begin
      tick();
      n++;
    end
    check("t4_pc31_reached", {27'd0, pc}, 32'd31);
    mem[1] = HALT;
    wait_halt(60, "t4_halt_reached");
    finish_test("t4", 5'd1, 16'd32, 1'b0);

    // 5: Done held high into the first EXEC cycle of the following add
    do_reset();
    mem[0] = 16'h000A;
    mem[1] = 16'h0091;
    done_at_q.push_back(1);
    done_at_q.push_back(3);
    sticky_q.push_back(1'b1);
    sticky_q.push_back(1'b0);
    exp_q.push_back(16'h000A);
    exp_q.push_back(16'h000A);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h0091);
    start = 1'b1;
    wait_halt(60, "t5_halt_reached");
    finish_test("t5", 5'd2, 16'd2, 1'b0);

    // 6: Done never returned
    do_reset();
    mem[0] = 16'h000A;
`ifdef WATCHDOG_EN
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h000A);
    start = 1'b1;
    wait_halt(40, "t6_halt_reached");
    finish_test("t6", 5'd0, 16'd0, 1'b1);
`else
    sb_en    = 1'b0;
    run_seen = 0;
    start    = 1'b1;
    tick(40);
    check("t6_run_count_ok", {31'd0, (run_seen >= 30)}, 32'd1);
    check("t6_still_run", {31'd0, bus.Run}, 32'd1);
    check("t6_not_halted", {31'd0, halted}, 32'd0);
    check("t6_timeout", {31'd0, timeout}, 32'd0);
    check("t6_pc", {27'd0, pc}, 32'd0);
    check("t6_instr_count", {16'd0, instr_count}, 32'd0);
`endif
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
